branch_predictor_gshare: RTL and testbench

Parametrised dynamic branch predictor for the pipelined MIPS core, replacing the single-bit, PC-indexed branch memory. It has a table of saturating counters, optionally indexed by PC XOR global branch history (gshare). The table is looked up combinationally in Decode and trained non-speculatively from Execute. It also keeps branch and mispredict statistics. The lookup index is exported so the pipeline can carry it to Execute, keeping update addressing exact when the history changes in between.

---
 rtl/branch_predictor_gshare.sv | 134 +++++++++++++
 tb/tb_branch_predictor_gshare.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_gshare.sv
// Dynamic branch predictor: a table of saturating counters indexed by PC, optionally XORed with
// a non-speculative global branch history (gshare). Lookup is combinational in Decode; training
// and statistics update at the rising edge on a resolved branch from Execute.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   pcD                  PC of the instruction in Decode
//   predict_takenD       MSB of the indexed counter
//   pred_idxD            table index used for pcD (carried to Execute by the datapath)
//   upd_en/idx/taken     training strobe, carried index and actual outcome
//   upd_mispredict       outcome differed from the prediction used (counted only with upd_en)
//   clear_stats          synchronous clear of both statistic counters
//   br_count             resolved branches since reset/clear (saturating)
//   mispred_count        mispredicts since reset/clear (saturating)
module branch_predictor_gshare #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned HIST_BITS  = 4,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned STAT_BITS  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pcD,
  output logic                  predict_takenD,
  output logic [INDEX_BITS-1:0] pred_idxD,
  input  logic                  upd_en,
  input  logic [INDEX_BITS-1:0] upd_idx,
  input  logic                  upd_taken,
  input  logic                  upd_mispredict,
  input  logic                  clear_stats,
  output logic [STAT_BITS-1:0]  br_count,
  output logic [STAT_BITS-1:0]  mispred_count
);

  localparam int Entries = 2 ** INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CtrMax  = {CTR_BITS{1'b1}};
  // Weakly-not-taken: MSB clear, all lower bits set.
  localparam logic [CTR_BITS-1:0] CtrInit = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [STAT_BITS-1:0] StatMax = {STAT_BITS{1'b1}};

  logic [CTR_BITS-1:0]   table_q [Entries];
  logic [CTR_BITS-1:0]   ctr_cur;
  logic [CTR_BITS-1:0]   ctr_d;
  logic [INDEX_BITS-1:0] pc_idx;
  logic [INDEX_BITS-1:0] hist_idx;
  logic [STAT_BITS-1:0]  br_q, br_d;
  logic [STAT_BITS-1:0]  mis_q, mis_d;
  logic                  unused_pc;

  assign pc_idx    = pcD[INDEX_BITS+1:2];
  assign unused_pc = ^{pcD[ADDR_WIDTH-1:INDEX_BITS+2], pcD[1:0]};

  if (HIST_BITS > 0) begin : g_hist
    logic [HIST_BITS-1:0] ghr_q, ghr_d;

    always_comb begin
      ghr_d    = ghr_q << 1;
      ghr_d[0] = upd_taken;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ghr_q <= '0;
      end else if (upd_en) begin
        ghr_q <= ghr_d;
      end
    end

    // History sits in the index LSBs, zero-extended.
    always_comb begin
      hist_idx                = '0;
      hist_idx[HIST_BITS-1:0] = ghr_q;
    end
  end else begin : g_no_hist
    assign hist_idx = '0;
  end

  // Lookup reads the pre-update table and history; no bypass from a same-cycle update.
  assign pred_idxD      = pc_idx ^ hist_idx;
  assign predict_takenD = table_q[pred_idxD][CTR_BITS-1];

  assign ctr_cur = table_q[upd_idx];

  always_comb begin
    ctr_d = ctr_cur;
    if (upd_taken && (ctr_cur != CtrMax)) begin
      ctr_d = ctr_cur + CTR_BITS'(1);
    end else if (!upd_taken && (ctr_cur != '0)) begin
      ctr_d = ctr_cur - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Entries; i++) begin
        table_q[i] <= CtrInit;
      end
    end else if (upd_en) begin
      table_q[upd_idx] <= ctr_d;
    end
  end

  // Clear has priority over a same-cycle increment.
  always_comb begin
    br_d  = br_q;
    mis_d = mis_q;
    if (clear_stats) begin
      br_d  = '0;
      mis_d = '0;
    end else if (upd_en) begin
      if (br_q != StatMax) begin
        br_d = br_q + STAT_BITS'(1);
      end
      if (upd_mispredict && (mis_q != StatMax)) begin
        mis_d = mis_q + STAT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_q  <= '0;
      mis_q <= '0;
    end else begin
      br_q  <= br_d;
      mis_q <= mis_d;
    end
  end

  assign br_count      = br_q;
  assign mispred_count = mis_q;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench for branch_predictor_gshare. Three instances share all inputs: a bimodal
// predictor, a gshare predictor with 4 history bits, and a bimodal one with 4-bit statistics.
module tb_branch_predictor_gshare;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcD;
  logic        upd_en;
  logic [5:0]  upd_idx;
  logic        upd_taken;
  logic        upd_mispredict;
  logic        clear_stats;

  logic        bim_pred, gsh_pred, st4_pred;
  logic [5:0]  bim_idx, gsh_idx, st4_idx;
  logic [31:0] bim_br, bim_mis, gsh_br, gsh_mis;
  logic [3:0]  st4_br, st4_mis;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  branch_predictor_gshare #(.HIST_BITS(0)) u_bim (
    .clk(clk), .reset(reset), .pcD(pcD), .predict_takenD(bim_pred), .pred_idxD(bim_idx),
    .upd_en(upd_en), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .clear_stats(clear_stats), .br_count(bim_br), .mispred_count(bim_mis)
  );

  branch_predictor_gshare #(.HIST_BITS(4)) u_gsh (
    .clk(clk), .reset(reset), .pcD(pcD), .predict_takenD(gsh_pred), .pred_idxD(gsh_idx),
    .upd_en(upd_en), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .clear_stats(clear_stats), .br_count(gsh_br), .mispred_count(gsh_mis)
  );

  branch_predictor_gshare #(.HIST_BITS(0), .STAT_BITS(4)) u_st4 (
    .clk(clk), .reset(reset), .pcD(pcD), .predict_takenD(st4_pred), .pred_idxD(st4_idx),
    .upd_en(upd_en), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .clear_stats(clear_stats), .br_count(st4_br), .mispred_count(st4_mis)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One training pulse; returns #1 after the capturing edge.
  task automatic do_upd(input logic [5:0] idx, input logic taken, input logic mis);
    @(negedge clk);
    upd_en         = 1'b1;
    upd_idx        = idx;
    upd_taken      = taken;
    upd_mispredict = mis;
    @(posedge clk);
    #1;
    upd_en         = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset          = 1'b0;
    pcD            = 32'h40;
    upd_en         = 1'b0;
    upd_idx        = '0;
    upd_taken      = 1'b0;
    upd_mispredict = 1'b0;
    clear_stats    = 1'b0;

    // Reset state, while held and after release.
    #12;
    check("rst_idx_held", 32'(bim_idx), 32'h10);
    check("rst_pred_held", 32'(bim_pred), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_idx", 32'(bim_idx), 32'h10);
    check("rst_pred", 32'(bim_pred), 32'h0);
    check("rst_br", bim_br, 32'h0);
    check("rst_gsh_idx", 32'(gsh_idx), 32'h10);

    // Bimodal saturation at idx 0x10: 01 -> 10 -> 11 -> 11.
    for (int i = 0; i < 3; i++) begin
      do_upd(6'h10, 1'b1, 1'b0);
      check($sformatf("sat_up%0d", i), 32'(bim_pred), 32'h1);
    end
    do_upd(6'h10, 1'b0, 1'b0);
    check("sat_dn0_10", 32'(bim_pred), 32'h1);
    do_upd(6'h10, 1'b0, 1'b0);
    check("sat_dn1_01", 32'(bim_pred), 32'h0);
    for (int i = 0; i < 3; i++) begin
      do_upd(6'h10, 1'b0, 1'b0);
      check($sformatf("sat_floor%0d", i), 32'(bim_pred), 32'h0);
    end
    // 00 -> 01 proves the floor held at 00.
    do_upd(6'h10, 1'b1, 1'b0);
    check("sat_floor_up", 32'(bim_pred), 32'h0);
    check("sat_br9", bim_br, 32'd9);

    // Same-cycle hazard, counter at 01: lookup sees the old value.
    @(negedge clk);
    upd_en    = 1'b1;
    upd_idx   = 6'h10;
    upd_taken = 1'b1;
    #1;
    check("haz_same", 32'(bim_pred), 32'h0);
    @(posedge clk);
    #1;
    upd_en = 1'b0;
    check("haz_next", 32'(bim_pred), 32'h1);

    // Gshare indexing: T,T,N,T at unrelated idx 0x05 -> ghr 1101.
    pulse_reset();
    pcD = 32'h40;
    do_upd(6'h05, 1'b1, 1'b0);
    check("gsh_idx_t1", 32'(gsh_idx), 32'h11);
    do_upd(6'h05, 1'b1, 1'b0);
    do_upd(6'h05, 1'b0, 1'b0);
    // Lookup during the 4th update uses the pre-update ghr 0110.
    @(negedge clk);
    upd_en    = 1'b1;
    upd_idx   = 6'h05;
    upd_taken = 1'b1;
    #1;
    check("gsh_idx_pre", 32'(gsh_idx), 32'h16);
    @(posedge clk);
    #1;
    upd_en = 1'b0;
    check("gsh_idx_1101", 32'(gsh_idx), 32'h1D);
    check("bim_idx_nohist", 32'(bim_idx), 32'h10);
    // Entry 5 went 01,10,11,10,11; PC bits 0x08 ^ 0xD = 0x05.
    pcD = 32'h20;
    #1;
    check("gsh_idx_e5", 32'(gsh_idx), 32'h05);
    check("gsh_pred_e5", 32'(gsh_pred), 32'h1);
    pcD = 32'h40;

    // Statistics: 5 updates, 2 mispredicts.
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      do_upd(6'h10, 1'b1, (i == 1 || i == 3));
    end
    check("st_br5", bim_br, 32'd5);
    check("st_mis2", bim_mis, 32'd2);
    // Mispredict flag alone is ignored.
    @(negedge clk);
    upd_mispredict = 1'b1;
    @(posedge clk);
    #1;
    upd_mispredict = 1'b0;
    check("st_mis_noen", bim_mis, 32'd2);
    check("st_br_noen", bim_br, 32'd5);
    // Clear beats same-cycle increments; table left intact.
    @(negedge clk);
    clear_stats    = 1'b1;
    upd_en         = 1'b1;
    upd_idx        = 6'h10;
    upd_taken      = 1'b1;
    upd_mispredict = 1'b1;
    @(posedge clk);
    #1;
    clear_stats    = 1'b0;
    upd_en         = 1'b0;
    upd_mispredict = 1'b0;
    check("clr_br", bim_br, 32'h0);
    check("clr_mis", bim_mis, 32'h0);
    check("clr_table_kept", 32'(bim_pred), 32'h1);

    // 4-bit statistics saturate at 15.
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      do_upd(6'h10, 1'b1, 1'b1);
    end
    check("st4_br_sat", 32'(st4_br), 32'd15);
    check("st4_mis_sat", 32'(st4_mis), 32'd15);
    check("bim_br20", bim_br, 32'd20);
    check("gsh_idx_1111", 32'(gsh_idx), 32'h1F);
    check("bim_pred_trained", 32'(bim_pred), 32'h1);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_bim_pred", 32'(bim_pred), 32'h0);
    check("arst_gsh_idx", 32'(gsh_idx), 32'h10);
    check("arst_br", bim_br, 32'h0);
    check("arst_st4_br", 32'(st4_br), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("arst_gsh_pred", 32'(gsh_pred), 32'h0);
    check("arst_gsh_idx_rel", 32'(gsh_idx), 32'h10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
